// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sequencing pipeline (p) and loader (d) onto DataMem.
// Optional misalignment check: define DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        p_valid,
  input  logic [31:0] p_addr,
  input  logic [1:0]  p_size,
  input  logic        p_wen,
  input  logic [31:0] p_wdata,
  output logic        p_ready,
  output logic        p_rvalid,
  output logic [31:0] p_rdata,
  output logic        p_err,

  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic        d_wen,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,

  output logic [31:0] mem_Addr,
  output logic [1:0]  mem_Size,
  output logic [31:0] mem_DataIn,
  output logic        mem_WEN,
  input  logic [31:0] mem_DataOut,

  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam int CW = 2;
  localparam logic [CW-1:0] LAST =
    CW'(MEM_LATENCY - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ptr_q, ptr_d;
  logic          gnt_q, gnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          wen_q, wen_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic        win_p, win_d, take;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_wen, req_bad;
  logic        in_idle, in_acc, in_resp;

  // ptr_q = 1 means d was granted last, so p wins a tie
  assign win_p = p_valid & (~d_valid | ptr_q);
  assign win_d = d_valid & (~p_valid | ~ptr_q);
  assign take  = win_p | win_d;

  assign req_addr  = win_p ? p_addr  : d_addr;
  assign req_size  = win_p ? p_size  : d_size;
  assign req_wen   = win_p ? p_wen   : d_wen;
  assign req_wdata = win_p ? p_wdata : d_wdata;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  always_comb begin
    req_bad = 1'b0;
    unique case (req_size)
      2'b01:   req_bad = req_addr[0];
      2'b10:   req_bad = |req_addr[1:0];
      2'b11:   req_bad = 1'b1;
      default: req_bad = 1'b0;
    endcase
  end
`else
  assign req_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          gnt_d   = win_d;
          ptr_d   = win_d;
          addr_d  = req_addr;
          size_d  = req_size;
          wen_d   = req_wen;
          wdata_d = req_wdata;
          rdata_d = 32'h0;
          err_d   = req_bad;
          cnt_d   = LAST;
          state_d = req_bad ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (wen_q) rdata_d = mem_DataOut;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b1;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wen_q   <= 1'b1;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign in_idle = (state_q == IDLE);
  assign in_acc  = (state_q == ACCESS);
  assign in_resp = (state_q == RESP);

  assign busy    = ~in_idle;
  assign p_ready = ~rst & in_idle & win_p;
  assign d_ready = ~rst & in_idle & win_d;

  assign mem_Addr   = in_acc ? addr_q  : 32'h0;
  assign mem_Size   = in_acc ? size_q  : 2'b00;
  assign mem_DataIn = in_acc ? wdata_q : 32'h0;
  // one write strobe per access, in its first cycle
  assign mem_WEN    = ~(in_acc & ~wen_q & (cnt_q == LAST));

  assign p_rvalid = in_resp & ~gnt_q;
  assign d_rvalid = in_resp & gnt_q;
  assign p_rdata  = p_rvalid ? rdata_q : 32'h0;
  assign d_rdata  = d_rvalid ? rdata_q : 32'h0;
  assign p_err    = p_rvalid & err_q;
  assign d_err    = d_rvalid & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: latency-1 and latency-3 instances
// checked every cycle against a transaction-level model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic        p_valid  [2];
  logic [31:0] p_addr   [2];
  logic [1:0]  p_size   [2];
  logic        p_wen    [2];
  logic [31:0] p_wdata  [2];
  logic        p_ready  [2];
  logic        p_rvalid [2];
  logic [31:0] p_rdata  [2];
  logic        p_err    [2];
  logic        d_valid  [2];
  logic [31:0] d_addr   [2];
  logic [1:0]  d_size   [2];
  logic        d_wen    [2];
  logic [31:0] d_wdata  [2];
  logic        d_ready  [2];
  logic        d_rvalid [2];
  logic [31:0] d_rdata  [2];
  logic        d_err    [2];
  logic [31:0] mem_Addr [2];
  logic [1:0]  mem_Size [2];
  logic [31:0] mem_DIn  [2];
  logic        mem_WEN  [2];
  logic [31:0] mem_DOut [2];
  logic        busy     [2];

  logic [31:0] dmem [2][64];
  assign mem_DOut[0] = dmem[0][mem_Addr[0][7:2]];
  assign mem_DOut[1] = dmem[1][mem_Addr[1][7:2]];

  dmem_arbiter #(.MEM_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst[0]),
    .p_valid(p_valid[0]), .p_addr(p_addr[0]),
    .p_size(p_size[0]), .p_wen(p_wen[0]),
    .p_wdata(p_wdata[0]), .p_ready(p_ready[0]),
    .p_rvalid(p_rvalid[0]), .p_rdata(p_rdata[0]),
    .p_err(p_err[0]),
    .d_valid(d_valid[0]), .d_addr(d_addr[0]),
    .d_size(d_size[0]), .d_wen(d_wen[0]),
    .d_wdata(d_wdata[0]), .d_ready(d_ready[0]),
    .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .d_err(d_err[0]),
    .mem_Addr(mem_Addr[0]), .mem_Size(mem_Size[0]),
    .mem_DataIn(mem_DIn[0]), .mem_WEN(mem_WEN[0]),
    .mem_DataOut(mem_DOut[0]), .busy(busy[0])
  );

  dmem_arbiter #(.MEM_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst[1]),
    .p_valid(p_valid[1]), .p_addr(p_addr[1]),
    .p_size(p_size[1]), .p_wen(p_wen[1]),
    .p_wdata(p_wdata[1]), .p_ready(p_ready[1]),
    .p_rvalid(p_rvalid[1]), .p_rdata(p_rdata[1]),
    .p_err(p_err[1]),
    .d_valid(d_valid[1]), .d_addr(d_addr[1]),
    .d_size(d_size[1]), .d_wen(d_wen[1]),
    .d_wdata(d_wdata[1]), .d_ready(d_ready[1]),
    .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .d_err(d_err[1]),
    .mem_Addr(mem_Addr[1]), .mem_Size(mem_Size[1]),
    .mem_DataIn(mem_DIn[1]), .mem_WEN(mem_WEN[1]),
    .mem_DataOut(mem_DOut[1]), .busy(busy[1])
  );

  // transaction model: one outstanding access, age counted from accept
  logic        m_act  [2];
  int          m_age  [2];
  logic        m_port [2];
  logic        m_last [2];
  logic        m_wr   [2];
  logic        m_err  [2];
  logic [31:0] m_addr [2];
  logic [1:0]  m_size [2];
  logic [31:0] m_wd   [2];
  logic [31:0] m_rd   [2];
  logic [31:0] m_mem  [2][64];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic        acc_seen [2];
  int          acc_cyc  [2];
  logic        rv_seen  [2];
  int          rv_cyc   [2];
  logic [31:0] rv_data  [2];
  logic        rv_err   [2];
  int          wen_lo   [2];
  int          viol     [2];
  logic [7:0]  gseq     [2];
  int          gcnt     [2];
  int          gcyc     [2][4];

  function automatic int lat(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic misal(logic [31:0] a,
                                 logic [1:0] s);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    return (s == 2'b11) ||
           (s == 2'b10 && a[1:0] != 2'b00) ||
           (s == 2'b01 && a[0]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string nm, int i,
                     logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s inst%0d got %h expected %h cyc %0d",
               nm, i, a, e, cyc);
    end
  endtask

  task automatic compare(int i);
    logic winp, wind, acc, resp, prv, drv;
    int rend;
    winp = p_valid[i] && (!d_valid[i] || m_last[i]);
    wind = d_valid[i] && (!p_valid[i] || !m_last[i]);
    rend = m_err[i] ? 1 : lat(i) + 1;
    acc  = m_act[i] && !m_err[i] && m_age[i] <= lat(i);
    resp = m_act[i] && m_age[i] == rend;
    prv  = resp && !m_port[i];
    drv  = resp && m_port[i];
    chk("p_ready", i, 32'(p_ready[i]),
        32'(!rst[i] && !m_act[i] && winp));
    chk("d_ready", i, 32'(d_ready[i]),
        32'(!rst[i] && !m_act[i] && wind));
    chk("busy", i, 32'(busy[i]), 32'(m_act[i]));
    chk("mem_Addr", i, mem_Addr[i],
        acc ? m_addr[i] : 32'h0);
    chk("mem_Size", i, 32'(mem_Size[i]),
        32'(acc ? m_size[i] : 2'b00));
    chk("mem_DataIn", i, mem_DIn[i],
        acc ? m_wd[i] : 32'h0);
    chk("mem_WEN", i, 32'(mem_WEN[i]),
        32'(!(acc && m_wr[i] && m_age[i] == 1)));
    chk("p_rvalid", i, 32'(p_rvalid[i]), 32'(prv));
    chk("p_rdata", i, p_rdata[i], prv ? m_rd[i] : 32'h0);
    chk("p_err", i, 32'(p_err[i]), 32'(prv && m_err[i]));
    chk("d_rvalid", i, 32'(d_rvalid[i]), 32'(drv));
    chk("d_rdata", i, d_rdata[i], drv ? m_rd[i] : 32'h0);
    chk("d_err", i, 32'(d_err[i]), 32'(drv && m_err[i]));
    if ((p_valid[i] && p_ready[i]) ||
        (d_valid[i] && d_ready[i])) begin
      acc_seen[i] = 1'b1;
      acc_cyc[i]  = cyc;
      gseq[i] = {gseq[i][6:0], !(p_valid[i] && p_ready[i])};
      if (gcnt[i] < 4) gcyc[i][gcnt[i]] = cyc;
      gcnt[i]++;
    end
    if ((p_rvalid[i] || d_rvalid[i]) && !rv_seen[i]) begin
      rv_seen[i] = 1'b1;
      rv_cyc[i]  = cyc;
      rv_data[i] = p_rvalid[i] ? p_rdata[i] : d_rdata[i];
      rv_err[i]  = p_rvalid[i] ? p_err[i] : d_err[i];
    end
    if (!mem_WEN[i]) begin
      wen_lo[i]++;
      dmem[i][mem_Addr[i][7:2]] = mem_DIn[i];
    end
    if (d_ready[i] && busy[i]) viol[i]++;
  endtask

  task automatic model_update(int i);
    logic winp, wind;
    winp = p_valid[i] && (!d_valid[i] || m_last[i]);
    wind = d_valid[i] && (!p_valid[i] || !m_last[i]);
    if (rst[i]) begin
      m_act[i]  = 1'b0;
      m_last[i] = 1'b1;
    end else if (m_act[i]) begin
      m_age[i]++;
      if (m_age[i] > (m_err[i] ? 1 : lat(i) + 1))
        m_act[i] = 1'b0;
    end else if (winp || wind) begin
      m_port[i] = wind;
      m_last[i] = wind;
      m_addr[i] = winp ? p_addr[i] : d_addr[i];
      m_size[i] = winp ? p_size[i] : d_size[i];
      m_wd[i]   = winp ? p_wdata[i] : d_wdata[i];
      m_wr[i]   = !(winp ? p_wen[i] : d_wen[i]);
      m_err[i]  = misal(m_addr[i], m_size[i]);
      m_rd[i]   = (m_wr[i] || m_err[i]) ? 32'h0 :
                  m_mem[i][m_addr[i][7:2]];
      if (m_wr[i] && !m_err[i])
        m_mem[i][m_addr[i][7:2]] = m_wd[i];
      m_act[i] = 1'b1;
      m_age[i] = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) compare(i);
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) model_update(i);
    #1;
  endtask

  task automatic clr_obs(int i);
    acc_seen[i] = 1'b0;
    rv_seen[i]  = 1'b0;
    wen_lo[i]   = 0;
  endtask

  task automatic set_req(int i, logic port, logic [31:0] a,
                         logic [1:0] s, logic wen,
                         logic [31:0] wd);
    if (!port) begin
      p_addr[i] = a; p_size[i] = s;
      p_wen[i] = wen; p_wdata[i] = wd; p_valid[i] = 1'b1;
    end else begin
      d_addr[i] = a; d_size[i] = s;
      d_wen[i] = wen; d_wdata[i] = wd; d_valid[i] = 1'b1;
    end
  endtask

  task automatic wait_acc(int i);
    for (int k = 0; k < 20 && !acc_seen[i]; k++) tick();
    chk("accept_wait", i, 32'(acc_seen[i]), 32'd1);
  endtask

  task automatic wait_rv(int i);
    for (int k = 0; k < 20 && !rv_seen[i]; k++) tick();
    chk("rvalid_wait", i, 32'(rv_seen[i]), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      p_valid[i] = 0; p_addr[i] = 0; p_size[i] = 0;
      p_wen[i] = 1; p_wdata[i] = 0;
      d_valid[i] = 0; d_addr[i] = 0; d_size[i] = 0;
      d_wen[i] = 1; d_wdata[i] = 0;
      m_act[i] = 0; m_age[i] = 0; m_port[i] = 0;
      m_last[i] = 1; m_wr[i] = 0; m_err[i] = 0;
      m_addr[i] = 0; m_size[i] = 0; m_wd[i] = 0; m_rd[i] = 0;
      gseq[i] = 0; gcnt[i] = 0; viol[i] = 0;
      acc_cyc[i] = 0; rv_cyc[i] = 0;
      rv_data[i] = 0; rv_err[i] = 0;
      for (int k = 0; k < 4; k++) gcyc[i][k] = 0;
      for (int k = 0; k < 64; k++) begin
        dmem[i][k] = 32'h0;
        m_mem[i][k] = 32'h0;
      end
      clr_obs(i);
    end
    dmem[0][8] = 32'hA5A5A5A5; m_mem[0][8] = 32'hA5A5A5A5;
    dmem[1][8] = 32'h12345678; m_mem[1][8] = 32'h12345678;

    tick(); tick();
    chk("rst_wen", 1, 32'(mem_WEN[1]), 32'd1);
    chk("rst_busy", 1, 32'(busy[1]), 32'd0);
    rst[0] = 0; rst[1] = 0;

    // latency 1: write then read back
    clr_obs(0);
    set_req(0, 0, 32'h10, 2'b10, 0, 32'hDEADBEEF);
    wait_acc(0);
    p_valid[0] = 0;
    wait_rv(0);
    chk("wr_lat", 0, rv_cyc[0] - acc_cyc[0], 2);
    chk("wr_wen_cnt", 0, wen_lo[0], 1);
    chk("wr_rdata", 0, rv_data[0], 32'h0);
    tick();
    clr_obs(0);
    set_req(0, 0, 32'h10, 2'b10, 1, 32'h0);
    wait_acc(0);
    p_valid[0] = 0;
    wait_rv(0);
    chk("rd_data", 0, rv_data[0], 32'hDEADBEEF);
    chk("rd_err", 0, 32'(rv_err[0]), 32'd0);
    chk("rd_wen_cnt", 0, wen_lo[0], 0);
    tick();

    // round robin from reset with both always valid
    rst[0] = 1; tick(); rst[0] = 0;
    gcnt[0] = 0; gseq[0] = 0; viol[0] = 0;
    set_req(0, 0, 32'h10, 2'b10, 1, 32'h0);
    set_req(0, 1, 32'h20, 2'b10, 1, 32'h0);
    for (int k = 0; k < 30 && gcnt[0] < 4; k++) tick();
    p_valid[0] = 0; d_valid[0] = 0;
    chk("rr_order", 0, 32'(gseq[0][3:0]), 32'h5);
    chk("rr_span", 0, gcyc[0][3] - gcyc[0][0], 9);
    repeat (4) tick();
    chk("rr_dready_busy", 0, viol[0], 0);

    // latency 3: back-to-back d reads
    clr_obs(1);
    gcnt[1] = 0;
    set_req(1, 1, 32'h20, 2'b10, 1, 32'h0);
    for (int k = 0; k < 30 && gcnt[1] < 2; k++) tick();
    d_valid[1] = 0;
    chk("l3_gap", 1, gcyc[1][1] - gcyc[1][0], 5);
    chk("l3_lat", 1, rv_cyc[1] - gcyc[1][0], 4);
    chk("l3_data", 1, rv_data[1], 32'h12345678);
    repeat (6) tick();

    // misaligned word write to 0x22
    clr_obs(0);
    set_req(0, 0, 32'h22, 2'b10, 0, 32'hCAFEF00D);
    wait_acc(0);
    p_valid[0] = 0;
    wait_rv(0);
    tick();
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    chk("mis_err", 0, 32'(rv_err[0]), 32'd1);
    chk("mis_lat", 0, rv_cyc[0] - acc_cyc[0], 1);
    chk("mis_wen", 0, wen_lo[0], 0);
    chk("mis_mem", 0, dmem[0][8], 32'hA5A5A5A5);
`else
    chk("mis_err", 0, 32'(rv_err[0]), 32'd0);
    chk("mis_lat", 0, rv_cyc[0] - acc_cyc[0], 2);
    chk("mis_wen", 0, wen_lo[0], 1);
    chk("mis_mem", 0, dmem[0][8], 32'hCAFEF00D);
`endif
    clr_obs(0);
    set_req(0, 0, 32'h10, 2'b11, 1, 32'h0);
    wait_acc(0);
    p_valid[0] = 0;
    wait_rv(0);
    tick();
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    chk("sz11", 0, rv_data[0], 32'h0);
`else
    chk("sz11", 0, rv_data[0], 32'hDEADBEEF);
`endif

    // reset during the second access cycle of a read
    clr_obs(1);
    set_req(1, 0, 32'h20, 2'b10, 1, 32'h0);
    wait_acc(1);
    p_valid[1] = 0;
    tick();
    rst[1] = 1; tick(); rst[1] = 0;
    chk("rst_busy2", 1, 32'(busy[1]), 32'd0);
    chk("rst_addr2", 1, mem_Addr[1], 32'h0);
    acc_seen[1] = 0;
    set_req(1, 0, 32'h20, 2'b10, 1, 32'h0);
    tick();
    chk("rst_reaccept", 1, 32'(acc_seen[1]), 32'd1);
    chk("rst_no_rv", 1, 32'(rv_seen[1]), 32'd0);
    p_valid[1] = 0;
    wait_rv(1);
    chk("rst_rd", 1, rv_data[1], 32'h12345678);
    tick();

    // p withdraws during d access; tie afterwards goes to p
    clr_obs(1);
    gcnt[1] = 0; gseq[1] = 0;
    set_req(1, 1, 32'h20, 2'b10, 1, 32'h0);
    wait_acc(1);
    d_valid[1] = 0;
    tick();
    set_req(1, 0, 32'h24, 2'b10, 1, 32'h0);
    tick();
    p_valid[1] = 0;
    repeat (3) tick();
    chk("wd_no_grant", 1, gcnt[1], 1);
    set_req(1, 0, 32'h24, 2'b10, 1, 32'h0);
    set_req(1, 1, 32'h20, 2'b10, 1, 32'h0);
    tick();
    p_valid[1] = 0; d_valid[1] = 0;
    chk("wd_tie_p", 1, gcnt[1], 2);
    chk("wd_tie_port", 1, 32'(gseq[1][0]), 32'd0);
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequences and shares the single DataMem port between two requesters: the pipeline MEM stage (port `p_`) and a secondary loader/debug master (port `d_`). Accepts one request at a time through a valid/ready handshake, arbitrates round-robin, and drives the DataMem address, size, data and active-low write enable for the configured access latency. Returns read data or a write acknowledge on a one-cycle response strobe. Sits between the MEM stage and DataMem.

## Interface
- `MEM_LATENCY`, default 1: cycles from address presentation to valid `mem_DataOut`; legal range 1..4.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `p_valid` in 1: pipeline request valid; held until accepted.
- `p_addr` in 32, `p_size` in 2 (00 byte, 01 half, 10 word), `p_wen` in 1 (0 = write, 1 = read), `p_wdata` in 32: pipeline request fields.
- `p_ready` out 1: pipeline request accepted this cycle when `p_valid` is also high.
- `p_rvalid` out 1, `p_rdata` out 32, `p_err` out 1: pipeline response strobe, data, error.
- `d_valid`, `d_addr`, `d_size`, `d_wen`, `d_wdata`, `d_ready`, `d_rvalid`, `d_rdata`, `d_err`: secondary port, same widths and meaning.
- `mem_Addr` out 32, `mem_Size` out 2, `mem_DataIn` out 32, `mem_WEN` out 1 (active-low): to DataMem.
- `mem_DataOut` in 32: from DataMem.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: `ready` is combinational and asserted only to the arbitration winner. Winner rules: only one valid wins; if both are valid, the port not granted last wins. The last-grant pointer resets to `d`, so `p` wins the first tie. Acceptance latches the request fields and the grant ID, updates the pointer, and moves to ACCESS.
- ACCESS: lasts exactly `MEM_LATENCY` cycles (down-counter).
  - `mem_Addr`, `mem_Size` and `mem_DataIn` are driven from the latched fields.
  - For writes, `mem_WEN` = 0 only in the first ACCESS cycle; otherwise it is 1.
  - For reads, `mem_DataOut` is captured on the edge ending the last ACCESS cycle.
- RESP: one cycle. The granted port's `rvalid` = 1, with `rdata` set to the captured word (0 for writes) and `err` = 0. Next state is IDLE.
- Outside ACCESS: `mem_Addr`, `mem_Size` and `mem_DataIn` = 0 and `mem_WEN` = 1.
- `rdata` and `err` are 0 whenever `rvalid` is 0. The non-granted port never sees `rvalid`.
- No request is accepted outside IDLE; `ready` is low in ACCESS and RESP. Requesters must hold their fields stable while `valid` is high and `ready` is low.

## Timing
- Accept at cycle T; ACCESS covers T+1 .. T+MEM_LATENCY; `rvalid` at T+MEM_LATENCY+1; IDLE at T+MEM_LATENCY+2. The next accept is possible at T+MEM_LATENCY+2.
- Sustained throughput is one access per MEM_LATENCY+2 cycles.
- Reset values: state IDLE, counter 0, pointer `d`. All `ready`, `rvalid`, `err` and `busy` = 0; all data outputs = 0; `mem_WEN` = 1.
- `rst` asserted in any state: the next state is IDLE and no `rvalid` is issued for the in-flight request.
  - A write whose `mem_WEN`=0 cycle coincides with `rst` still commits, because DataMem is not reset.
- `valid` dropped before acceptance: the request is withdrawn and the pointer is not updated.

## Configuration
- `DMEM_ARB_ALIGN_CHECK_EN` defined:
  - At acceptance, the latched request is checked. It is an error if: half with `addr[0]`=1; word with `addr[1:0]`≠0; or size 2'b11.
  - An erroring request skips ACCESS and goes IDLE→RESP. `mem_WEN` stays 1; the response has `err` = 1 and `rdata` = 0. Latency accept→`rvalid` is 1 cycle.
- Undefined: no check; all requests, including size 11, go to DataMem unchanged, and `err` is tied to 0.

## Test plan
- MEM_LATENCY=1: `p` writes word 0xDEADBEEF to 0x10, then reads 0x10. The write produces one `mem_WEN`=0 cycle and `p_rvalid` 2 cycles after accept; the read returns `p_rdata`=0xDEADBEEF, `p_err`=0.
- Both valid from reset with continuous requests: grants go p, d, p, d; each `rvalid` reaches only its own port; `d_ready` is never high while `busy`=1.
- MEM_LATENCY=3: `d` reads 0x20 (preloaded 0x12345678). `d_rvalid` arrives 4 cycles after accept with 0x12345678, and the next accept is 5 cycles after the first.
- With `DMEM_ARB_ALIGN_CHECK_EN`: `p` writes a word to 0x22. Expect `p_rvalid`=1 and `p_err`=1 one cycle after accept, `mem_WEN` never 0, and memory at 0x20 unchanged. Without the macro, the access reaches DataMem and `err` stays 0.
- `rst` pulsed in the second ACCESS cycle of a read (MEM_LATENCY=3): no `rvalid`, all outputs return to reset values, and a `p` request on the following cycle is accepted immediately.
- `p_valid` raised then dropped while `d` is mid-access: no `p` grant, and the pointer is unchanged.
